// File: rtl/cfm_uart_pkg.sv
// cfm_uart_pkg: shared UART constants, receiver state encoding and 2-of-3 vote helper
package cfm_uart_pkg;

    localparam int UART_DATA_BITS       = 8;
    localparam int UART_DEFAULT_DIVISOR = 345;

    typedef enum logic [2:0] {
        ST_ARM,
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } uart_rx_state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchronizer for an asynchronous input pin, with selectable reset value
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_core,
    input  logic resetn,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    // shift the raw pin through two flops before anyone looks at it
    always_ff @(posedge clk_core or negedge resetn) begin
        if (!resetn) sync_q <= {2{RESET_VAL}};
        else         sync_q <= {sync_q[0], d_i};
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with one-byte holding register and sticky error flags; define UART_RX_MAJORITY_EN for 2-of-3 sample voting
module uart_rx
    import cfm_uart_pkg::*;
#(
    parameter int DIVISOR = UART_DEFAULT_DIVISOR
) (
    input  logic                      clk_core,
    input  logic                      resetn,
    input  logic                      rx,
    output logic [UART_DATA_BITS-1:0] rx_data,
    output logic                      rx_valid,
    input  logic                      rx_ack,
    input  logic                      err_clr,
    output logic                      rx_overrun,
    output logic                      rx_frame_err
);

    localparam int            CW   = $clog2(DIVISOR);
    localparam logic [CW-1:0] FULL = CW'(DIVISOR - 1);
    localparam logic [CW-1:0] HALF = CW'(DIVISOR / 2 - 1);
    localparam logic [2:0]    LAST = 3'(UART_DATA_BITS - 1);

    logic                      rx_s;
    uart_rx_state_t            state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [2:0]                idx_q, idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic [UART_DATA_BITS-1:0] data_q, data_d;
    logic                      valid_q, valid_d;
    logic                      ovr_q, ovr_d;
    logic                      ferr_q, ferr_d;
    logic [1:0]                warm_q;
    logic                      counting, tick, samp, deliver, ferr_ev, accept;

    uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk_core (clk_core),
        .resetn   (resetn),
        .d_i      (rx),
        .q_o      (rx_s)
    );

    assign counting = (state_q == ST_START) || (state_q == ST_DATA) || (state_q == ST_STOP);

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist_q;
    logic       tick_q;

    // remember the two previous line samples and delay the expiry by one cycle so the vote sees expiry-1..expiry+1
    always_ff @(posedge clk_core or negedge resetn) begin
        if (!resetn) begin
            hist_q <= 2'b11;
            tick_q <= 1'b0;
        end else begin
            hist_q <= {hist_q[0], rx_s};
            tick_q <= counting && (cnt_q == '0);
        end
    end

    assign tick = tick_q;
    assign samp = maj3(hist_q[1], hist_q[0], rx_s);
`else
    assign tick = counting && (cnt_q == '0);
    assign samp = rx_s;
`endif

    // frame-level state machine: bit timing, shifting and stop-bit verdict
    always_comb begin
        state_d = state_q;
        cnt_d   = counting ? ((cnt_q == '0) ? FULL : cnt_q - 1'b1) : cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        deliver = 1'b0;
        ferr_ev = 1'b0;
        case (state_q)
            ST_ARM:   if (warm_q[1] && rx_s) state_d = ST_IDLE;
            ST_IDLE:  if (!rx_s) begin
                          state_d = ST_START;
                          cnt_d   = HALF;
                      end
            ST_START: if (tick) begin
                          state_d = samp ? ST_IDLE : ST_DATA;
                          idx_d   = '0;
                      end
            ST_DATA:  if (tick) begin
                          shift_d = {samp, shift_q[UART_DATA_BITS-1:1]};
                          state_d = (idx_q == LAST) ? ST_STOP : ST_DATA;
                          idx_d   = (idx_q == LAST) ? idx_q : idx_q + 3'd1;
                      end
            ST_STOP:  if (tick) begin
                          state_d = samp ? ST_IDLE : ST_BREAK;
                          deliver = samp;
                          ferr_ev = !samp;
                      end
            ST_BREAK: if (rx_s) state_d = ST_IDLE;
            default:  state_d = ST_ARM;
        endcase
    end

    // holding register and sticky flags; a same-cycle event beats a pop or clear
    always_comb begin
        accept  = deliver && (!valid_q || rx_ack);
        valid_d = accept || (valid_q && !rx_ack);
        data_d  = accept ? shift_q : data_q;
        ovr_d   = (deliver && !accept) || (ovr_q && !err_clr);
        ferr_d  = ferr_ev || (ferr_q && !err_clr);
    end

    // state registers; warm_q keeps ARM from trusting the synchronizer's reset value as a real line sample
    always_ff @(posedge clk_core or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_ARM;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
            warm_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            ferr_q  <= ferr_d;
            warm_q  <= {warm_q[0], 1'b1};
        end
    end

    assign rx_data      = data_q;
    assign rx_valid     = valid_q;
    assign rx_overrun   = ovr_q;
    assign rx_frame_err = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed, table-driven self-checking bench for uart_rx at DIVISOR=16
module tb_uart_rx;
    import cfm_uart_pkg::*;

    localparam int DIV = 16;
`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif
    localparam int DEL = 9 * DIV + DIV / 2 + 2 + MAJ;

    logic       clk_core = 1'b0;
    logic       resetn;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack;
    logic       err_clr;
    logic       rx_overrun;
    logic       rx_frame_err;

    int checks = 0;
    int errors = 0;
    int lat;

    typedef struct {
        logic [7:0] d;
        int         stop_bits;
        logic       stop_val;
        logic       exp_valid;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[6];

    uart_rx #(.DIVISOR(DIV)) dut (
        .clk_core     (clk_core),
        .resetn       (resetn),
        .rx           (rx),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ack       (rx_ack),
        .err_clr      (err_clr),
        .rx_overrun   (rx_overrun),
        .rx_frame_err (rx_frame_err)
    );

    always #5 clk_core = ~clk_core;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) begin
            @(posedge clk_core);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] d, input int stop_bits, input logic stop_val,
                        input int ack_at, input int clr_at, input int spike_at);
        logic [8:0] f;
        logic       prev;
        f    = {d, 1'b0};
        lat  = -1;
        prev = rx_valid;
        for (int i = 0; i < (9 + stop_bits) * DIV; i++) begin
            int b;
            b       = i / DIV;
            rx      = (b < 9) ? f[b] : stop_val;
            if (i == spike_at) rx = ~rx;
            rx_ack  = (i == ack_at);
            err_clr = (i == clr_at);
            @(posedge clk_core);
            #1;
            if (lat < 0 && rx_valid && !prev) lat = i + 1;
            prev = rx_valid;
        end
        rx      = 1'b1;
        rx_ack  = 1'b0;
        err_clr = 1'b0;
    endtask

    task automatic pop_clear();
        rx_ack  = 1'b1;
        err_clr = 1'b1;
        @(posedge clk_core);
        #1;
        rx_ack  = 1'b0;
        err_clr = 1'b0;
    endtask

    initial begin
        vecs[0] = '{8'hA5, 1, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{8'h12, 1, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 1, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{8'h00, 1, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{8'h55, 3, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{8'h0F, 1, 1'b1, 1'b1, 1'b0};

        resetn  = 1'b0;
        rx      = 1'b1;
        rx_ack  = 1'b0;
        err_clr = 1'b0;
        repeat (3) @(posedge clk_core);
        #1;
        check("reset_valid", rx_valid, 0);
        check("reset_data", rx_data, 0);
        check("reset_overrun", rx_overrun, 0);
        check("reset_ferr", rx_frame_err, 0);
        check("reset_state", dut.state_q, ST_ARM);
        resetn = 1'b1;
        idle(10);
        check("armed_idle", dut.state_q, ST_IDLE);

        for (int k = 0; k < 6; k++) begin
            send(vecs[k].d, vecs[k].stop_bits, vecs[k].stop_val, -1, -1, -1);
            idle(8);
            if (k == 0) check("latency", lat, 9 * DIV + DIV / 2 + 3 + MAJ);
            check($sformatf("vec%0d_valid", k), rx_valid, vecs[k].exp_valid);
            if (vecs[k].exp_valid) check($sformatf("vec%0d_data", k), rx_data, vecs[k].d);
            check($sformatf("vec%0d_ferr", k), rx_frame_err, vecs[k].exp_ferr);
            check($sformatf("vec%0d_overrun", k), rx_overrun, 0);
            pop_clear();
            check($sformatf("vec%0d_pop_valid", k), rx_valid, 0);
            check($sformatf("vec%0d_clr_ferr", k), rx_frame_err, 0);
        end

        send(8'h3C, 1, 1'b1, -1, -1, -1);
        send(8'hC3, 1, 1'b1, -1, -1, -1);
        idle(4);
        check("ovr_data", rx_data, 8'h3C);
        check("ovr_valid", rx_valid, 1);
        check("ovr_flag", rx_overrun, 1);
        pop_clear();
        check("ovr_clr", rx_overrun, 0);
        send(8'h3C, 1, 1'b1, -1, -1, -1);
        send(8'hC3, 1, 1'b1, DEL, -1, -1);
        idle(4);
        check("ackdel_data", rx_data, 8'hC3);
        check("ackdel_valid", rx_valid, 1);
        check("ackdel_overrun", rx_overrun, 0);
        pop_clear();

        rx = 1'b0;
        repeat (4) begin
            @(posedge clk_core);
            #1;
        end
        idle(40);
        check("glitch_valid", rx_valid, 0);
        check("glitch_ferr", rx_frame_err, 0);
        check("glitch_overrun", rx_overrun, 0);
        check("glitch_state", dut.state_q, ST_IDLE);

`ifdef UART_RX_MAJORITY_EN
        send(8'hA5, 1, 1'b1, -1, -1, 40);
        idle(4);
        check("spike_valid", rx_valid, 1);
        check("spike_data", rx_data, 8'hA5);
        pop_clear();
`endif

        send(8'h55, 3, 1'b0, -1, DEL, -1);
        idle(8);
        check("clr_vs_ferr", rx_frame_err, 1);
        check("clr_vs_ferr_valid", rx_valid, 0);
        pop_clear();
        check("clr_ferr_after", rx_frame_err, 0);

        send(8'h5A, 1, 1'b1, -1, -1, -1);
        send(8'h66, 1, 1'b1, -1, -1, -1);
        idle(4);
        check("pre_rst_valid", rx_valid, 1);
        check("pre_rst_overrun", rx_overrun, 1);
        rx = 1'b0;
        repeat (40) begin
            @(posedge clk_core);
            #1;
        end
        resetn = 1'b0;
        #2;
        check("midrst_valid", rx_valid, 0);
        check("midrst_data", rx_data, 0);
        check("midrst_overrun", rx_overrun, 0);
        repeat (3) @(posedge clk_core);
        #1;
        resetn = 1'b1;
        repeat (200) begin
            @(posedge clk_core);
            #1;
        end
        check("midrst_state", dut.state_q, ST_ARM);
        check("midrst_hold_valid", rx_valid, 0);
        check("midrst_hold_ferr", rx_frame_err, 0);
        idle(20);
        send(8'h81, 1, 1'b1, -1, -1, -1);
        idle(4);
        check("post_rst_valid", rx_valid, 1);
        check("post_rst_data", rx_data, 8'h81);
        check("post_rst_ferr", rx_frame_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
